// File: rtl/arm_pkg.sv
// Shared ARM fetch definitions: condition/opcode field encodings and fetch FSM states.
package arm_pkg;

  localparam logic [3:0] COND_AL   = 4'hE;
  localparam logic [2:0] OP_BRANCH = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational B/BL target and sequential-address calculation (mod 2^32).
module branch_target_calc (
  input  logic [31:0] pc_i,
  input  logic [23:0] imm24_i,
  output logic [31:0] target_o,
  output logic [31:0] pcPlus4_o
);

  logic [31:0] offset;

  // Word offset: sign-extend imm24 then shift left by two.
  assign offset    = {{6{imm24_i[23]}}, imm24_i, 2'b00};
  assign target_o  = pc_i + 32'd8 + offset;
  assign pcPlus4_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_fold_stage.sv
// Fetch stage: drives instruction memory, buffers one instruction toward decode and folds
// unconditional B/BL locally (BL also issues the R14 link write).
module fetch_fold_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             link_we,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] fold_count
);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pcF_q, pcF_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outInstr_q, outInstr_d;
  logic [31:0]      outPc_q, outPc_d;
  logic             linkWe_q, linkWe_d;
  logic [31:0]      linkData_q, linkData_d;
  logic [CNT_W-1:0] foldCount_q, foldCount_d;

  logic        accept;
  logic        isFold;
  logic        isBl;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  branch_target_calc u_target (
    .pc_i      (pcF_q),
    .imm24_i   (imem_rd[23:0]),
    .target_o  (target),
    .pcPlus4_o (pcPlus4)
  );

  assign accept = !outValid_q || out_ready;
  assign isFold = (imem_rd[31:28] == COND_AL) && (imem_rd[27:25] == OP_BRANCH);
  assign isBl   = isFold && imem_rd[24];

  always_comb begin
    state_d     = state_q;
    pcF_d       = pcF_q;
    outValid_d  = outValid_q;
    outInstr_d  = outInstr_q;
    outPc_d     = outPc_q;
    linkWe_d    = 1'b0;
    linkData_d  = linkData_q;
    foldCount_d = foldCount_q;

    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Execute redirect wins over everything, including a held slot.
          pcF_d      = {redirect_pc[31:2], 2'b00};
          outValid_d = 1'b0;
        end else if (!accept) begin
          // Stall: hold everything.
        end else if (isFold) begin
          pcF_d      = target;
          outValid_d = 1'b0;
          if (foldCount_q != '1) begin
            foldCount_d = foldCount_q + CNT_W'(1);
          end
          if (isBl) begin
            linkWe_d   = 1'b1;
            linkData_d = pcPlus4;
          end
        end else begin
          outInstr_d = imem_rd;
          outPc_d    = pcF_q;
          outValid_d = 1'b1;
          pcF_d      = pcPlus4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pcF_q       <= RESET_PC;
      outValid_q  <= 1'b0;
      outInstr_q  <= 32'h0;
      outPc_q     <= 32'h0;
      linkWe_q    <= 1'b0;
      linkData_q  <= 32'h0;
      foldCount_q <= '0;
    end else begin
      state_q     <= state_d;
      pcF_q       <= pcF_d;
      outValid_q  <= outValid_d;
      outInstr_q  <= outInstr_d;
      outPc_q     <= outPc_d;
      linkWe_q    <= linkWe_d;
      linkData_q  <= linkData_d;
      foldCount_q <= foldCount_d;
    end
  end

  assign imem_addr  = pcF_q;
  assign out_valid  = outValid_q;
  assign out_instr  = outInstr_q;
  assign out_pc     = outPc_q;
  assign link_we    = linkWe_q;
  assign link_data  = linkData_q;
  assign fold_count = foldCount_q;

endmodule

// File: tb/tb_fetch_fold_stage.sv
// Directed bench for fetch_fold_stage with a combinational instruction memory model.
module tb_fetch_fold_stage;

  localparam logic [31:0] NOP   = 32'hE1A0_0000;
  localparam logic [31:0] BL0   = 32'hEB00_0000;
  localparam logic [31:0] BSELF = 32'hEAFF_FFFE;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic [31:0] link_data;
  logic [3:0]  fold_count;

  logic [31:0] mem [128];
  int tests = 0;
  int fails = 0;
  logic prevLinkWe = 1'b0;

  assign imem_rd = mem[imem_addr[8:2]];

  always #5 clk = ~clk;

  fetch_fold_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_data      (link_data),
    .fold_count     (fold_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous invariants: single-cycle link pulse, word-aligned out_pc.
  always @(negedge clk) begin
    if (!reset) begin
      prevLinkWe = 1'b0;
    end else begin
      check("link_pulse_width", {31'b0, prevLinkWe & link_we}, 32'h0);
      check("out_pc_aligned", {30'b0, out_pc[1:0]}, 32'h0);
      prevLinkWe = link_we;
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[4]         = BSELF;  // 0x10: self-loop B
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 reset = 1'b0;
    tick();
    tick();
    // Reset values
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_link_we", {31'b0, link_we}, 32'h0);
    check("rst_link_data", link_data, 32'h0);
    check("rst_fold", {28'b0, fold_count}, 32'h0);

    // T1: one idle cycle, then sequential NOP stream
    reset = 1'b1;
    tick();
    check("t1_idle_valid", {31'b0, out_valid}, 32'h0);
    check("t1_idle_addr", imem_addr, 32'h0);
    tick();
    check("t1_valid0", {31'b0, out_valid}, 32'h1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_instr0", out_instr, NOP);
    check("t1_addr4", imem_addr, 32'h4);
    tick();
    check("t1_pc4", out_pc, 32'h4);
    tick();
    check("t1_pc8", out_pc, 32'h8);
    check("t1_addrC", imem_addr, 32'hC);

    // T4: stall holds everything
    out_ready = 1'b0;
    tick();
    check("t4_hold_pc", out_pc, 32'h8);
    check("t4_hold_addr", imem_addr, 32'hC);
    check("t4_hold_valid", {31'b0, out_valid}, 32'h1);
    tick();
    check("t4_hold_addr2", imem_addr, 32'hC);
    check("t4_hold_fold", {28'b0, fold_count}, 32'h0);
    out_ready = 1'b1;
    tick();
    check("t4_release_pc", out_pc, 32'hC);
    check("t4_release_addr", imem_addr, 32'h10);

    // Redirect to 0 (beats the self-loop fold at 0x10), BL now at 0
    mem[0]         = BL0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check("redir0_addr", imem_addr, 32'h0);
    check("redir0_valid", {31'b0, out_valid}, 32'h0);
    check("redir0_fold", {28'b0, fold_count}, 32'h0);
    redirect_valid = 1'b0;

    // T2: folded BL +0
    tick();
    check("t2_link_we", {31'b0, link_we}, 32'h1);
    check("t2_link_data", link_data, 32'h4);
    check("t2_addr", imem_addr, 32'h8);
    check("t2_valid", {31'b0, out_valid}, 32'h0);
    check("t2_fold", {28'b0, fold_count}, 32'h1);
    tick();
    check("t2_link_we_drop", {31'b0, link_we}, 32'h0);
    check("t2_link_data_hold", link_data, 32'h4);
    check("t2_next_pc", out_pc, 32'h8);
    check("t2_next_valid", {31'b0, out_valid}, 32'h1);
    tick();
    check("t3_pre_addr", imem_addr, 32'h10);

    // T3: self-loop B saturates the counter
    tick();
    check("t3_fold2", {28'b0, fold_count}, 32'h2);
    check("t3_addr", imem_addr, 32'h10);
    check("t3_valid", {31'b0, out_valid}, 32'h0);
    check("t3_no_link", {31'b0, link_we}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t3_loop_addr", imem_addr, 32'h10);
    end
    check("t3_saturated", {28'b0, fold_count}, 32'hF);

    // T5: redirect flushes a stalled slot, BL at pc_f suppressed
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    check("t5_escape_addr", imem_addr, 32'h20);
    check("t5_escape_fold", {28'b0, fold_count}, 32'hF);
    mem[9]         = BL0;  // 0x24
    redirect_valid = 1'b0;
    tick();
    check("t5_slot_pc", out_pc, 32'h20);
    check("t5_slot_valid", {31'b0, out_valid}, 32'h1);
    check("t5_slot_addr", imem_addr, 32'h24);
    out_ready = 1'b0;
    tick();
    check("t5_stall_addr", imem_addr, 32'h24);
    check("t5_stall_link", {31'b0, link_we}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    check("t5_flush_valid", {31'b0, out_valid}, 32'h0);
    check("t5_flush_addr", imem_addr, 32'h100);
    check("t5_flush_link", {31'b0, link_we}, 32'h0);
    check("t5_flush_fold", {28'b0, fold_count}, 32'hF);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    check("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // T6: reset during the link_we cycle
    tick();
    check("t6_link_we_pre", {31'b0, link_we}, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_link_we", {31'b0, link_we}, 32'h0);
    check("t6_link_data", link_data, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_fold", {28'b0, fold_count}, 32'h0);
    check("t6_pc", out_pc, 32'h0);
    mem[0] = NOP;
    tick();
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    check("idle_redirect_ignored", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    tick();
    check("t6b_pc0", out_pc, 32'h0);
    tick();
    check("t6b_pc4", out_pc, 32'h4);
    out_ready = 1'b0;
    tick();
    check("t6b_stall_addr", imem_addr, 32'h8);
    // Reset mid-stall
    reset = 1'b0;
    #1;
    check("t6b_valid", {31'b0, out_valid}, 32'h0);
    check("t6b_instr", out_instr, 32'h0);
    check("t6b_addr", imem_addr, 32'h0);
    check("t6b_outpc", out_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
